d_asm: RTL and testbench

D_ASM -- requirements
Module: d_asm

---
 rtl/d_asm_pkg.sv | 87 ++++++++
 rtl/d_asm_reg_fmt.sv | 31 +++
 rtl/d_asm.sv | 225 ++++++++++++++++++++++
 tb/tb_d_asm.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/d_asm_pkg.sv
// d_asm_pkg: MIPS-I field constants, ASCII constants, ABI register-name
// table and small text-token helpers shared by the disassembler.
// A "token" is a 128-bit, left-justified run of up to 16 ASCII bytes.
// Unused trailing bytes are 0x00, so a token's length is implied by its contents.
package d_asm_pkg;

  // primary opcodes
  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02,
                         OP_JAL     = 6'h03, OP_BEQ    = 6'h04, OP_BNE   = 6'h05,
                         OP_BLEZ    = 6'h06, OP_BGTZ   = 6'h07, OP_ADDI  = 6'h08,
                         OP_ADDIU   = 6'h09, OP_SLTI   = 6'h0a, OP_SLTIU = 6'h0b,
                         OP_ANDI    = 6'h0c, OP_ORI    = 6'h0d, OP_XORI  = 6'h0e,
                         OP_LUI     = 6'h0f, OP_COP0   = 6'h10, OP_LB    = 6'h20,
                         OP_LH      = 6'h21, OP_LW     = 6'h23, OP_LBU   = 6'h24,
                         OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29,
                         OP_SW      = 6'h2b;

  // SPECIAL funct codes
  localparam logic [5:0] FN_SLL  = 6'h00, FN_SRL  = 6'h02, FN_SRA   = 6'h03,
                         FN_SLLV = 6'h04, FN_SRLV = 6'h06, FN_SRAV  = 6'h07,
                         FN_JR   = 6'h08, FN_JALR = 6'h09, FN_MFHI  = 6'h10,
                         FN_MTHI = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
                         FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1a,
                         FN_DIVU = 6'h1b, FN_ADD  = 6'h20, FN_ADDU  = 6'h21,
                         FN_SUB  = 6'h22, FN_SUBU = 6'h23, FN_AND   = 6'h24,
                         FN_OR   = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
                         FN_SLT  = 6'h2a, FN_SLTU = 6'h2b, FN_ERET  = 6'h18;

  // REGIMM rt selectors and COP0 rs selectors
  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;
  localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;

  // ASCII
  localparam logic [7:0]  CH_SP = 8'h20, CH_DOLLAR = 8'h24, CH_COMMA = 8'h2c,
                          CH_LPAR = 8'h28, CH_RPAR = 8'h29, CH_0 = 8'h30;
  localparam logic [15:0] HEX_PFX = 16'h3078; // "0x"

  // ABI names, space padded to 5 characters
  localparam logic [0:31][39:0] REG_SYM = {
    "$zero", "$at  ", "$v0  ", "$v1  ", "$a0  ", "$a1  ", "$a2  ", "$a3  ",
    "$t0  ", "$t1  ", "$t2  ", "$t3  ", "$t4  ", "$t5  ", "$t6  ", "$t7  ",
    "$s0  ", "$s1  ", "$s2  ", "$s3  ", "$s4  ", "$s5  ", "$s6  ", "$s7  ",
    "$t8  ", "$t9  ", "$k0  ", "$k1  ", "$gp  ", "$sp  ", "$fp  ", "$ra  "};

  // operand layout selected by the decoder
  typedef enum logic [3:0] {
    F_NONE, F_RD_RS_RT, F_RD_RT_SA, F_RS, F_RD, F_RD_RS, F_RS_RT, F_RT_C0,
    F_RT_RS_IMM, F_RT_IMM, F_MEM, F_RS_RT_BR, F_RS_BR, F_JMP
  } form_e;

  function automatic logic [7:0] hex_ch(input logic [3:0] d);
    return (d < 4'd10) ? (CH_0 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction

  // two ASCII decimal digits (tens, ones) of a 0..31 value
  function automatic logic [15:0] dec2(input logic [4:0] n);
    logic [4:0] t;
    t = n / 5'd10;
    return {CH_0 + {3'b0, t}, CH_0 + {3'b0, n - t * 5'd10}};
  endfunction

  function automatic int tok_len(input logic [127:0] t);
    int n;
    n = 0;
    for (int i = 0; i < 16; i++)
      if (t[127-8*i -: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  // drop leading NUL bytes (e.g. from a right-justified string literal)
  function automatic logic [127:0] tok_lj(input logic [127:0] s);
    int   z;
    logic seen;
    z = 0;
    seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!seen && s[127-8*i -: 8] == 8'h00) z++;
      else seen = 1'b1;
    end
    return s << (8 * z);
  endfunction

  function automatic logic [127:0] tok_cat(input logic [127:0] a, input logic [127:0] b);
    return a | (b >> (8 * tok_len(a)));
  endfunction

endpackage

// File: rtl/d_asm_reg_fmt.sv
// d_asm_reg_fmt: register number -> left-justified 5-char field plus length.
// mode=0 gives "$<decimal>", mode=1 gives the ABI name.
module d_asm_reg_fmt
  import d_asm_pkg::*;
(
  input  logic [4:0]  num,
  input  logic        mode,
  output logic [39:0] field,
  output logic [2:0]  len
);

  logic [15:0] d;
  assign d = dec2(num);

  // pick symbolic or decimal spelling
  always_comb begin
    field = {5{CH_SP}};
    len   = 3'd0;
    if (mode) begin
      field = REG_SYM[num];
      len   = (num == 5'd0) ? 3'd5 : 3'd3;
    end else if (num < 5'd10) begin
      field = {CH_DOLLAR, d[7:0], {3{CH_SP}}};
      len   = 3'd2;
    end else begin
      field = {CH_DOLLAR, d, {2{CH_SP}}};
      len   = 3'd3;
    end
  end

endmodule

// File: rtl/d_asm.sv
// d_asm: registered MIPS-I disassembler producing a 32-character ASCII line.
// Optional feature macro: D_ASM_REGNAME_EN enables symbolic register names
// through reg_name; without it names are always numeric.
module d_asm
  import d_asm_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic [31:0]  pc,
  input  logic [31:0]  instr,
  input  logic         reg_name,
  output logic [255:0] asm
);

  localparam int NREG = 4; // rs, rt, rd, cop0 rd

  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sa;
  logic [15:0] imm;
  logic [31:0] pc4, btgt, jtgt;
  logic        sym;

  assign op   = instr[31:26];
  assign rs   = instr[25:21];
  assign rt   = instr[20:16];
  assign rd   = instr[15:11];
  assign sa   = instr[10:6];
  assign fn   = instr[5:0];
  assign imm  = instr[15:0];
  assign pc4  = pc + 32'd4;
  assign btgt = pc4 + {{14{imm[15]}}, imm, 2'b00};
  assign jtgt = {pc4[31:28], instr[25:0], 2'b00};

`ifdef D_ASM_REGNAME_EN
  assign sym = reg_name;
`else
  logic unused_reg_name;
  assign unused_reg_name = reg_name;
  assign sym = 1'b0;
`endif

  // register name formatters; cop0 registers are always numeric
  logic [NREG-1:0][4:0]  rnum;
  logic [NREG-1:0]       rmode;
  logic [NREG-1:0][39:0] rfld;
  logic [NREG-1:0][2:0]  rlen;

  assign rnum  = {rd, rd, rt, rs};
  assign rmode = {1'b0, sym, sym, sym};

  genvar g;
  for (g = 0; g < NREG; g++) begin : g_reg
    d_asm_reg_fmt u_fmt (
      .num  (rnum[g]),
      .mode (rmode[g]),
      .field(rfld[g]),
      .len  (rlen[g])
    );
  end

  function automatic logic [127:0] reg_tok(input logic [39:0] f, input logic [2:0] n);
    logic [127:0] t;
    t = {f, 88'h0};
    return t & ~({128{1'b1}} >> (8 * n));
  endfunction

  function automatic int ln_len(input logic [255:0] l);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++)
      if (l[255-8*i -: 8] != 8'h00) n = i + 1;
    return n;
  endfunction

  // anything pushed past character 31 falls off the end
  function automatic logic [255:0] ln_app(input logic [255:0] l, input logic [127:0] t);
    return l | ({t, 128'h0} >> (8 * ln_len(l)));
  endfunction

  // operand tokens
  logic [127:0] rs_t, rt_t, rd_t, c0_t, imm_t, sa_t, br_t, j_t, mem_t;
  logic [15:0]  sa_d;

  assign rs_t  = reg_tok(rfld[0], rlen[0]);
  assign rt_t  = reg_tok(rfld[1], rlen[1]);
  assign rd_t  = reg_tok(rfld[2], rlen[2]);
  assign c0_t  = reg_tok(rfld[3], rlen[3]);
  assign imm_t = {HEX_PFX, hex_ch(imm[15:12]), hex_ch(imm[11:8]),
                  hex_ch(imm[7:4]), hex_ch(imm[3:0]), 80'h0};
  assign br_t  = {HEX_PFX, hex_ch(btgt[31:28]), hex_ch(btgt[27:24]), hex_ch(btgt[23:20]),
                  hex_ch(btgt[19:16]), hex_ch(btgt[15:12]), hex_ch(btgt[11:8]),
                  hex_ch(btgt[7:4]), hex_ch(btgt[3:0]), 48'h0};
  assign j_t   = {HEX_PFX, hex_ch(jtgt[31:28]), hex_ch(jtgt[27:24]), hex_ch(jtgt[23:20]),
                  hex_ch(jtgt[19:16]), hex_ch(jtgt[15:12]), hex_ch(jtgt[11:8]),
                  hex_ch(jtgt[7:4]), hex_ch(jtgt[3:0]), 48'h0};
  assign sa_d  = dec2(sa);
  assign sa_t  = (sa < 5'd10) ? {sa_d[7:0], 120'h0} : {sa_d, 112'h0};
  assign mem_t = tok_cat(tok_cat(tok_cat(imm_t, {CH_LPAR, 120'h0}), rs_t), {CH_RPAR, 120'h0});

  // decode: mnemonic text and operand layout
  logic [63:0] mn;
  form_e       form;

  always_comb begin
    mn   = 64'("unknown");
    form = F_NONE;
    case (op)
      OP_SPECIAL: begin
        if (instr == 32'h0) mn = 64'("nop");
        else begin
          case (fn)
            FN_SLL:   begin mn = 64'("sll");   form = F_RD_RT_SA; end
            FN_SRL:   begin mn = 64'("srl");   form = F_RD_RT_SA; end
            FN_SRA:   begin mn = 64'("sra");   form = F_RD_RT_SA; end
            FN_SLLV:  begin mn = 64'("sllv");  form = F_RD_RS_RT; end
            FN_SRLV:  begin mn = 64'("srlv");  form = F_RD_RS_RT; end
            FN_SRAV:  begin mn = 64'("srav");  form = F_RD_RS_RT; end
            FN_JR:    begin mn = 64'("jr");    form = F_RS;       end
            FN_JALR:  begin mn = 64'("jalr");  form = F_RD_RS;    end
            FN_MFHI:  begin mn = 64'("mfhi");  form = F_RD;       end
            FN_MTHI:  begin mn = 64'("mthi");  form = F_RS;       end
            FN_MFLO:  begin mn = 64'("mflo");  form = F_RD;       end
            FN_MTLO:  begin mn = 64'("mtlo");  form = F_RS;       end
            FN_MULT:  begin mn = 64'("mult");  form = F_RS_RT;    end
            FN_MULTU: begin mn = 64'("multu"); form = F_RS_RT;    end
            FN_DIV:   begin mn = 64'("div");   form = F_RS_RT;    end
            FN_DIVU:  begin mn = 64'("divu");  form = F_RS_RT;    end
            FN_ADD:   begin mn = 64'("add");   form = F_RD_RS_RT; end
            FN_ADDU:  begin mn = 64'("addu");  form = F_RD_RS_RT; end
            FN_SUB:   begin mn = 64'("sub");   form = F_RD_RS_RT; end
            FN_SUBU:  begin mn = 64'("subu");  form = F_RD_RS_RT; end
            FN_AND:   begin mn = 64'("and");   form = F_RD_RS_RT; end
            FN_OR:    begin mn = 64'("or");    form = F_RD_RS_RT; end
            FN_XOR:   begin mn = 64'("xor");   form = F_RD_RS_RT; end
            FN_NOR:   begin mn = 64'("nor");   form = F_RD_RS_RT; end
            FN_SLT:   begin mn = 64'("slt");   form = F_RD_RS_RT; end
            FN_SLTU:  begin mn = 64'("sltu");  form = F_RD_RS_RT; end
            default: ;
          endcase
        end
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ)      begin mn = 64'("bltz"); form = F_RS_BR; end
        else if (rt == RT_BGEZ) begin mn = 64'("bgez"); form = F_RS_BR; end
      end
      OP_J:     begin mn = 64'("j");     form = F_JMP;       end
      OP_JAL:   begin mn = 64'("jal");   form = F_JMP;       end
      OP_BEQ:   begin mn = 64'("beq");   form = F_RS_RT_BR;  end
      OP_BNE:   begin mn = 64'("bne");   form = F_RS_RT_BR;  end
      OP_BLEZ:  begin mn = 64'("blez");  form = F_RS_BR;     end
      OP_BGTZ:  begin mn = 64'("bgtz");  form = F_RS_BR;     end
      OP_ADDI:  begin mn = 64'("addi");  form = F_RT_RS_IMM; end
      OP_ADDIU: begin mn = 64'("addiu"); form = F_RT_RS_IMM; end
      OP_SLTI:  begin mn = 64'("slti");  form = F_RT_RS_IMM; end
      OP_SLTIU: begin mn = 64'("sltiu"); form = F_RT_RS_IMM; end
      OP_ANDI:  begin mn = 64'("andi");  form = F_RT_RS_IMM; end
      OP_ORI:   begin mn = 64'("ori");   form = F_RT_RS_IMM; end
      OP_XORI:  begin mn = 64'("xori");  form = F_RT_RS_IMM; end
      OP_LUI:   begin mn = 64'("lui");   form = F_RT_IMM;    end
      OP_COP0: begin
        if (rs == RS_MF)                       begin mn = 64'("mfc0"); form = F_RT_C0; end
        else if (rs == RS_MT)                  begin mn = 64'("mtc0"); form = F_RT_C0; end
        else if (rs == RS_CO && fn == FN_ERET) mn = 64'("eret");
      end
      OP_LB:    begin mn = 64'("lb");    form = F_MEM; end
      OP_LH:    begin mn = 64'("lh");    form = F_MEM; end
      OP_LW:    begin mn = 64'("lw");    form = F_MEM; end
      OP_LBU:   begin mn = 64'("lbu");   form = F_MEM; end
      OP_LHU:   begin mn = 64'("lhu");   form = F_MEM; end
      OP_SB:    begin mn = 64'("sb");    form = F_MEM; end
      OP_SH:    begin mn = 64'("sh");    form = F_MEM; end
      OP_SW:    begin mn = 64'("sw");    form = F_MEM; end
      default: ;
    endcase
  end

  // map the layout onto an ordered operand list
  logic [127:0] o0, o1, o2;
  logic [1:0]   nops;

  always_comb begin
    o0 = '0; o1 = '0; o2 = '0; nops = 2'd0;
    case (form)
      F_RD_RS_RT:  begin o0 = rd_t; o1 = rs_t;  o2 = rt_t;  nops = 2'd3; end
      F_RD_RT_SA:  begin o0 = rd_t; o1 = rt_t;  o2 = sa_t;  nops = 2'd3; end
      F_RS:        begin o0 = rs_t;                         nops = 2'd1; end
      F_RD:        begin o0 = rd_t;                         nops = 2'd1; end
      F_RD_RS:     begin o0 = rd_t; o1 = rs_t;              nops = 2'd2; end
      F_RS_RT:     begin o0 = rs_t; o1 = rt_t;              nops = 2'd2; end
      F_RT_C0:     begin o0 = rt_t; o1 = c0_t;              nops = 2'd2; end
      F_RT_RS_IMM: begin o0 = rt_t; o1 = rs_t;  o2 = imm_t; nops = 2'd3; end
      F_RT_IMM:    begin o0 = rt_t; o1 = imm_t;             nops = 2'd2; end
      F_MEM:       begin o0 = rt_t; o1 = mem_t;             nops = 2'd2; end
      F_RS_RT_BR:  begin o0 = rs_t; o1 = rt_t;  o2 = br_t;  nops = 2'd3; end
      F_RS_BR:     begin o0 = rs_t; o1 = br_t;              nops = 2'd2; end
      F_JMP:       begin o0 = j_t;                          nops = 2'd1; end
      default: ;
    endcase
  end

  // assemble the line, then turn unused NUL bytes into spaces
  logic [127:0] sep;
  logic [255:0] line;

  assign sep = {CH_COMMA, CH_SP, 112'h0};

  always_comb begin
    line = {tok_lj({mn, 64'h0}), 128'h0};
    if (nops != 2'd0) begin
      line = ln_app(line, {CH_SP, 120'h0});
      line = ln_app(line, o0);
    end
    if (nops > 2'd1) line = ln_app(ln_app(line, sep), o1);
    if (nops > 2'd2) line = ln_app(ln_app(line, sep), o2);
    for (int i = 0; i < 32; i++)
      if (line[255-8*i -: 8] == 8'h00) line[255-8*i -: 8] = CH_SP;
  end

  // output register; reset shows a blank line
  always_ff @(posedge clk) begin
    if (reset) asm <= {32{CH_SP}};
    else       asm <= line;
  end

endmodule

// File: tb/tb_d_asm.sv
// tb_d_asm: directed and randomized checks of d_asm against a string-level
// reference disassembler built with $sformatf.
module tb_d_asm;

  logic         clk = 1'b0;
  logic         reset;
  logic [31:0]  pc, instr;
  logic         reg_name;
  logic [255:0] asm;

  int n_tests = 0;
  int n_fail  = 0;

  d_asm dut (.clk(clk), .reset(reset), .pc(pc), .instr(instr), .reg_name(reg_name), .asm(asm));

  always #5 clk = ~clk;

  string abi [32] = '{"$zero","$at","$v0","$v1","$a0","$a1","$a2","$a3",
                      "$t0","$t1","$t2","$t3","$t4","$t5","$t6","$t7",
                      "$s0","$s1","$s2","$s3","$s4","$s5","$s6","$s7",
                      "$t8","$t9","$k0","$k1","$gp","$sp","$fp","$ra"};

  function automatic logic [255:0] pack(input string s);
    logic [255:0] r;
    r = {32{8'h20}};
    for (int i = 0; i < 32; i++)
      if (i < s.len()) r[255-8*i -: 8] = s[i];
    return r;
  endfunction

  function automatic string rn(input int n, input bit sym);
    return sym ? abi[n] : $sformatf("$%0d", n);
  endfunction

  // reference disassembler
  function automatic string dis(input logic [31:0] p, input logic [31:0] w, input bit sym);
    int op, fn, sa, rd;
    string RS, RT, RD, H, BT, JT;
    longint off;
    logic [31:0] bt, p4;
    op = int'(w[31:26]); fn = int'(w[5:0]); sa = int'(w[10:6]); rd = int'(w[15:11]);
    RS = rn(int'(w[25:21]), sym); RT = rn(int'(w[20:16]), sym); RD = rn(rd, sym);
    H  = $sformatf("0x%04h", w[15:0]);
    off = (w[15] ? longint'(w[15:0]) - 65536 : longint'(w[15:0])) * 4;
    p4 = p + 32'd4;
    bt = 32'(longint'(p4) + off);
    BT = $sformatf("0x%08h", bt);
    JT = $sformatf("0x%08h", {p4[31:28], w[25:0], 2'b00});
    if (w == 32'h0) return "nop";
    case (op)
      0: case (fn)
        0:  return $sformatf("sll %s, %s, %0d", RD, RT, sa);
        2:  return $sformatf("srl %s, %s, %0d", RD, RT, sa);
        3:  return $sformatf("sra %s, %s, %0d", RD, RT, sa);
        4:  return $sformatf("sllv %s, %s, %s", RD, RS, RT);
        6:  return $sformatf("srlv %s, %s, %s", RD, RS, RT);
        7:  return $sformatf("srav %s, %s, %s", RD, RS, RT);
        8:  return {"jr ", RS};
        9:  return {"jalr ", RD, ", ", RS};
        16: return {"mfhi ", RD};
        17: return {"mthi ", RS};
        18: return {"mflo ", RD};
        19: return {"mtlo ", RS};
        24: return {"mult ", RS, ", ", RT};
        25: return {"multu ", RS, ", ", RT};
        26: return {"div ", RS, ", ", RT};
        27: return {"divu ", RS, ", ", RT};
        32: return {"add ", RD, ", ", RS, ", ", RT};
        33: return {"addu ", RD, ", ", RS, ", ", RT};
        34: return {"sub ", RD, ", ", RS, ", ", RT};
        35: return {"subu ", RD, ", ", RS, ", ", RT};
        36: return {"and ", RD, ", ", RS, ", ", RT};
        37: return {"or ", RD, ", ", RS, ", ", RT};
        38: return {"xor ", RD, ", ", RS, ", ", RT};
        39: return {"nor ", RD, ", ", RS, ", ", RT};
        42: return {"slt ", RD, ", ", RS, ", ", RT};
        43: return {"sltu ", RD, ", ", RS, ", ", RT};
        default: return "unknown";
      endcase
      1: if (w[20:16] == 0) return {"bltz ", RS, ", ", BT};
         else if (w[20:16] == 1) return {"bgez ", RS, ", ", BT};
         else return "unknown";
      2:  return {"j ", JT};
      3:  return {"jal ", JT};
      4:  return {"beq ", RS, ", ", RT, ", ", BT};
      5:  return {"bne ", RS, ", ", RT, ", ", BT};
      6:  return {"blez ", RS, ", ", BT};
      7:  return {"bgtz ", RS, ", ", BT};
      8:  return {"addi ", RT, ", ", RS, ", ", H};
      9:  return {"addiu ", RT, ", ", RS, ", ", H};
      10: return {"slti ", RT, ", ", RS, ", ", H};
      11: return {"sltiu ", RT, ", ", RS, ", ", H};
      12: return {"andi ", RT, ", ", RS, ", ", H};
      13: return {"ori ", RT, ", ", RS, ", ", H};
      14: return {"xori ", RT, ", ", RS, ", ", H};
      15: return {"lui ", RT, ", ", H};
      16: if (w[25:21] == 0) return $sformatf("mfc0 %s, $%0d", RT, rd);
          else if (w[25:21] == 4) return $sformatf("mtc0 %s, $%0d", RT, rd);
          else if (w[25:21] == 16 && fn == 24) return "eret";
          else return "unknown";
      32: return {"lb ", RT, ", ", H, "(", RS, ")"};
      33: return {"lh ", RT, ", ", H, "(", RS, ")"};
      35: return {"lw ", RT, ", ", H, "(", RS, ")"};
      36: return {"lbu ", RT, ", ", H, "(", RS, ")"};
      37: return {"lhu ", RT, ", ", H, "(", RS, ")"};
      40: return {"sb ", RT, ", ", H, "(", RS, ")"};
      41: return {"sh ", RT, ", ", H, "(", RS, ")"};
      43: return {"sw ", RT, ", ", H, "(", RS, ")"};
      default: return "unknown";
    endcase
  endfunction

  // mostly-legal random instruction words
  logic [5:0] ops [25] = '{6'h00,6'h01,6'h02,6'h03,6'h04,6'h05,6'h06,6'h07,6'h08,6'h09,
                           6'h0a,6'h0b,6'h0c,6'h0d,6'h0e,6'h0f,6'h10,6'h20,6'h21,6'h23,
                           6'h24,6'h25,6'h28,6'h29,6'h2b};
  logic [5:0] fns [26] = '{6'h00,6'h02,6'h03,6'h04,6'h06,6'h07,6'h08,6'h09,6'h10,6'h11,
                           6'h12,6'h13,6'h18,6'h19,6'h1a,6'h1b,6'h20,6'h21,6'h22,6'h23,
                           6'h24,6'h25,6'h26,6'h27,6'h2a,6'h2b};

  function automatic logic [31:0] gen();
    logic [31:0] w;
    logic [4:0]  c0rs [3] = '{5'h00, 5'h04, 5'h10};
    w = $urandom;
    if ($urandom_range(0, 9) == 0) return w;
    w[31:26] = ops[$urandom_range(0, 24)];
    case (w[31:26])
      6'h00: w[5:0] = fns[$urandom_range(0, 25)];
      6'h01: w[20:16] = 5'($urandom_range(0, 2));
      6'h10: begin
        w[25:21] = c0rs[$urandom_range(0, 2)];
        if (w[25:21] == 5'h10) w[5:0] = 6'h18;
      end
      default: ;
    endcase
    return w;
  endfunction

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got \"%s\" want \"%s\"", tag, got, exp);
    end
  endtask

  task automatic step(input logic r, input logic [31:0] p, input logic [31:0] w, input logic m);
    reset = r; pc = p; instr = w; reg_name = m;
    @(posedge clk);
    #1;
  endtask

  bit          sym_en;
  logic [31:0] rp, rw;
  logic        rm, rr;

  initial begin
`ifdef D_ASM_REGNAME_EN
    sym_en = 1'b1;
`else
    sym_en = 1'b0;
`endif
    reset = 1'b1; pc = '0; instr = '0; reg_name = 1'b0;
    #2;
    step(1'b1, 32'h0, 32'h0, 1'b0);
    check("reset_blank", asm, {32{8'h20}});
    step(1'b0, 32'h0, 32'h0, 1'b0);
    check("nop", asm, pack("nop"));
    step(1'b0, 32'h0, 32'h00221821, 1'b0);
    check("addu", asm, pack("addu $3, $1, $2"));
    step(1'b0, 32'h0, 32'h3c01abcd, 1'b0);
    check("lui", asm, pack("lui $1, 0xabcd"));
    step(1'b0, 32'h0, 32'h8fbf0010, 1'b1);
    check("lw_regname", asm, pack(sym_en ? "lw $ra, 0x0010($sp)" : "lw $31, 0x0010($29)"));
    step(1'b0, 32'h00003000, 32'h1000ffff, 1'b0);
    check("beq_back", asm, pack("beq $0, $0, 0x00003000"));
    step(1'b0, 32'h00003004, 32'h0c000c00, 1'b0);
    check("jal", asm, pack("jal 0x00003000"));
    step(1'b0, 32'h0, 32'hfc000000, 1'b0);
    check("unknown", asm, pack("unknown"));
    step(1'b0, 32'hfffffffc, 32'h10000001, 1'b0);
    check("beq_wrap", asm, pack("beq $0, $0, 0x00000004"));
    step(1'b0, 32'h0, 32'h001f07c3, 1'b0);
    check("sra_sa31", asm, pack("sra $0, $31, 31"));
    step(1'b0, 32'h0, 32'h40886000, 1'b1);
    check("mtc0", asm, pack(sym_en ? "mtc0 $t0, $12" : "mtc0 $8, $12"));
    step(1'b0, 32'h0, 32'h42000018, 1'b0);
    check("eret", asm, pack("eret"));
    step(1'b1, 32'h0, 32'h00221821, 1'b0);
    check("reset_mid", asm, {32{8'h20}});

    for (int i = 0; i < 400; i++) begin
      rw = gen();
      rp = $urandom & 32'hfffffffc;
      rm = 1'($urandom_range(0, 1));
      rr = ($urandom_range(0, 19) == 0);
      step(rr, rp, rw, rm);
      check($sformatf("rnd pc=%08h w=%08h m=%0d r=%0d", rp, rw, rm, rr), asm,
            rr ? {32{8'h20}} : pack(dis(rp, rw, sym_en && rm)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
